// File: rtl/arith_fifo_engine.sv
// Input FIFO -> shared sequential multiply/divide engine -> output FIFO.
// Each queued operand pair selects its own operation; results carry mode and divide-by-zero flags.
module arith_fifo_engine #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_req,
    input  logic                    op_mode,
    input  logic [2*W-1:0]          fifo_write_data,
    output logic [$clog2(DEPTH):0]  in_left_sig,
    output logic                    in_overflow,
    input  logic                    read_req,
    output logic                    result_valid,
    output logic [2*W-1:0]          result_data,
    output logic                    result_mode,
    output logic                    result_div0,
    output logic [$clog2(DEPTH):0]  out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = 2 * W + 1;
    localparam int EW = 2 * W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [NW-1:0] LAST_C  = NW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // input FIFO storage and control
    logic [IW-1:0] in_mem [DEPTH];
    logic [AW-1:0] in_wr_ptr_r;
    logic [AW-1:0] in_rd_ptr_r;
    logic [CW-1:0] in_used_r;
    logic          in_ready_r;
    logic          in_overflow_r;
    logic          in_push_s;
    logic [IW-1:0] in_head_s;

    // output FIFO storage and control
    logic [EW-1:0] out_mem [DEPTH];
    logic [AW-1:0] out_wr_ptr_r;
    logic [AW-1:0] out_rd_ptr_r;
    logic [CW-1:0] out_used_r;
    logic          out_push_s;
    logic          out_pop_s;
    logic [EW-1:0] out_head_s;

    // engine
    state_t         state_r;
    state_t         state_next_s;
    logic           eng_pop_s;
    logic [NW-1:0]  cnt_r;
    logic           mode_r;
    logic           div0_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   bsh_r;
    logic [2*W-1:0] msh_r;
    logic [2*W-1:0] acc_r;
    logic [W-1:0]   dsh_r;
    logic [W-1:0]   rem_r;
    logic [W-1:0]   quo_r;
    logic [W:0]     rem_shift_s;
    logic           rem_ge_s;
    logic [W-1:0]   rem_next_s;
    logic [2*W-1:0] result_s;

    assign in_head_s   = in_mem[in_rd_ptr_r];
    assign in_push_s   = write_req && ((in_used_r != DEPTH_C) || eng_pop_s);
    assign in_left_sig = DEPTH_C - in_used_r;
    assign in_overflow = in_overflow_r;

    assign out_head_s   = out_mem[out_rd_ptr_r];
    assign out_pop_s    = read_req && (out_used_r != '0);
    assign out_count    = out_used_r;
    assign result_valid = (out_used_r != '0);

    // Input FIFO data array
    always_ff @(posedge clk) begin
        if (in_push_s) begin
            in_mem[in_wr_ptr_r] <= {op_mode, fifo_write_data};
        end
    end

    // Input FIFO pointers, occupancy and overflow pulse; in_ready_r is a one-cycle
    // delayed view of "not empty" that the engine waits on before it pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_ptr_r   <= '0;
            in_rd_ptr_r   <= '0;
            in_used_r     <= '0;
            in_ready_r    <= 1'b0;
            in_overflow_r <= 1'b0;
        end else begin
            in_ready_r    <= (in_used_r != '0);
            in_overflow_r <= write_req && !in_push_s;
            if (in_push_s) begin
                in_wr_ptr_r <= in_wr_ptr_r + AW'(1);
            end
            if (eng_pop_s) begin
                in_rd_ptr_r <= in_rd_ptr_r + AW'(1);
            end
            case ({in_push_s, eng_pop_s})
                2'b10:   in_used_r <= in_used_r + CW'(1);
                2'b01:   in_used_r <= in_used_r - CW'(1);
                default: in_used_r <= in_used_r;
            endcase
        end
    end

    // Output FIFO data array
    always_ff @(posedge clk) begin
        if (out_push_s) begin
            out_mem[out_wr_ptr_r] <= {div0_r, mode_r, result_s};
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr_ptr_r <= '0;
            out_rd_ptr_r <= '0;
            out_used_r   <= '0;
        end else begin
            if (out_push_s) begin
                out_wr_ptr_r <= out_wr_ptr_r + AW'(1);
            end
            if (out_pop_s) begin
                out_rd_ptr_r <= out_rd_ptr_r + AW'(1);
            end
            case ({out_push_s, out_pop_s})
                2'b10:   out_used_r <= out_used_r + CW'(1);
                2'b01:   out_used_r <= out_used_r - CW'(1);
                default: out_used_r <= out_used_r;
            endcase
        end
    end

    // Show-ahead head word, forced to zero while the output FIFO is empty
    always_comb begin
        if (result_valid) begin
            result_div0 = out_head_s[EW-1];
            result_mode = out_head_s[EW-2];
            result_data = out_head_s[2*W-1:0];
        end else begin
            result_div0 = 1'b0;
            result_mode = 1'b0;
            result_data = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (eng_pop_s) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_C) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: pop the input FIFO only when a result slot is guaranteed
    always_comb begin
        eng_pop_s  = 1'b0;
        out_push_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_ready_r && (in_used_r != '0) && (out_used_r != DEPTH_C)) begin
                    eng_pop_s = 1'b1;
                end else begin
                    eng_pop_s = 1'b0;
                end
            end
            DONE:    out_push_s = 1'b1;
            default: out_push_s = 1'b0;
        endcase
    end

    // Restoring-divide step; a zero divisor naturally yields all-ones quotient and remainder = a
    always_comb begin
        rem_shift_s = {rem_r, dsh_r[W-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, b_r});
        if (rem_ge_s) begin
            rem_next_s = rem_shift_s[W-1:0] - b_r;
        end else begin
            rem_next_s = rem_shift_s[W-1:0];
        end
        if (mode_r) begin
            result_s = {rem_r, quo_r};
        end else begin
            result_s = acc_r;
        end
    end

    // Engine datapath: operand latch in IDLE, one multiply or divide iteration per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            mode_r <= 1'b0;
            div0_r <= 1'b0;
            b_r    <= '0;
            bsh_r  <= '0;
            msh_r  <= '0;
            acc_r  <= '0;
            dsh_r  <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (eng_pop_s) begin
                        cnt_r  <= '0;
                        mode_r <= in_head_s[2*W];
                        div0_r <= in_head_s[2*W] && (in_head_s[W-1:0] == '0);
                        b_r    <= in_head_s[W-1:0];
                        bsh_r  <= in_head_s[W-1:0];
                        msh_r  <= {{W{1'b0}}, in_head_s[2*W-1:W]};
                        dsh_r  <= in_head_s[2*W-1:W];
                        acc_r  <= '0;
                        rem_r  <= '0;
                        quo_r  <= '0;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + NW'(1);
                    if (mode_r) begin
                        rem_r <= rem_next_s;
                        quo_r <= {quo_r[W-2:0], rem_ge_s};
                        dsh_r <= dsh_r << 1;
                    end else begin
                        if (bsh_r[0]) begin
                            acc_r <= acc_r + msh_r;
                        end
                        msh_r <= msh_r << 1;
                        bsh_r <= bsh_r >> 1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_fifo_engine.sv
// Scoreboard bench for arith_fifo_engine: expected results are queued on accepted
// writes and compared as the consumer pops them.
module tb_arith_fifo_engine;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 2 * W + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           write_req = 1'b0;
    logic           op_mode = 1'b0;
    logic [2*W-1:0] fifo_write_data = '0;
    logic           read_req = 1'b0;
    logic [CW-1:0]  in_left_sig;
    logic           in_overflow;
    logic           result_valid;
    logic [2*W-1:0] result_data;
    logic           result_mode;
    logic           result_div0;
    logic [CW-1:0]  out_count;

    int vectors = 0;
    int miscompares = 0;
    logic [EW-1:0] sb [$];

    arith_fifo_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .write_req       (write_req),
        .op_mode         (op_mode),
        .fifo_write_data (fifo_write_data),
        .in_left_sig     (in_left_sig),
        .in_overflow     (in_overflow),
        .read_req        (read_req),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_mode     (result_mode),
        .result_div0     (result_div0),
        .out_count       (out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        if (!m) begin
            return {1'b0, 1'b0, wa * wb};
        end
        if (b == '0) begin
            return {1'b1, 1'b1, a, {W{1'b1}}};
        end
        q = a / b;
        r = a % b;
        return {1'b0, 1'b1, r, q};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_one(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        if (in_left_sig != '0) begin
            sb.push_back(model(m, a, b));
        end
        op_mode         = m;
        fifo_write_data = {a, b};
        write_req       = 1'b1;
        cycle();
        write_req = 1'b0;
    endtask

    task automatic read_one(output bit ok, output logic [EW-1:0] word);
        for (int k = 0; k < 400 && !result_valid; k++) begin
            cycle();
        end
        ok   = result_valid;
        word = {result_div0, result_mode, result_data};
        if (ok) begin
            read_req = 1'b1;
            cycle();
            read_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        vectors += 7;
        if (in_left_sig !== CW'(DEPTH)) begin miscompares++; $display("FAIL reset_in_left actual=%0d expected=%0d", in_left_sig, DEPTH); end
        if (in_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow actual=%0b expected=0", in_overflow); end
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid actual=%0b expected=0", result_valid); end
        if (result_data !== '0) begin miscompares++; $display("FAIL reset_data actual=%h expected=0", result_data); end
        if (result_mode !== 1'b0) begin miscompares++; $display("FAIL reset_mode actual=%0b expected=0", result_mode); end
        if (result_div0 !== 1'b0) begin miscompares++; $display("FAIL reset_div0 actual=%0b expected=0", result_div0); end
        if (out_count !== '0) begin miscompares++; $display("FAIL reset_out_count actual=%0d expected=0", out_count); end
    endtask

    task automatic test_latency_mul();
        bit ok;
        logic [EW-1:0] word;
        logic [EW-1:0] exp;
        int k;
        write_one(1'b0, 8'd200, 8'd100);
        k = 0;
        while (!result_valid && k < 50) begin
            cycle();
            k++;
        end
        vectors++;
        if (k != W + 3) begin miscompares++; $display("FAIL latency actual=%0d expected=%0d", k, W + 3); end
        read_one(ok, word);
        exp = sb.pop_front();
        vectors++;
        if (!ok || word !== exp) begin miscompares++; $display("FAIL mul_200x100 actual=%h expected=%h ok=%0d", word, exp, ok); end
    endtask

    task automatic test_div();
        bit ok;
        logic [EW-1:0] word;
        logic [EW-1:0] exp;
        write_one(1'b1, 8'd200, 8'd7);
        write_one(1'b1, 8'd200, 8'd0);
        write_one(1'b1, 8'd9, 8'd3);
        for (int i = 0; i < 3; i++) begin
            read_one(ok, word);
            exp = sb.pop_front();
            vectors++;
            if (!ok || word !== exp) begin miscompares++; $display("FAIL div_%0d actual=%h expected=%h ok=%0d", i, word, exp, ok); end
        end
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic m;
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    for (int k = 0; k < 500 && in_left_sig == '0; k++) cycle();
                    m = 1'($urandom_range(0, 1));
                    a = W'($urandom_range(0, 255));
                    b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(0, 255));
                    write_one(m, a, b);
                    repeat ($urandom_range(0, 3)) cycle();
                end
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    bit ok;
                    logic [EW-1:0] word;
                    logic [EW-1:0] exp;
                    repeat ($urandom_range(0, 15)) cycle();
                    vectors++;
                    if (result_valid !== (out_count != '0) || out_count > CW'(DEPTH) || in_left_sig > CW'(DEPTH)) begin
                        miscompares++;
                        $display("FAIL rand_counts valid=%0b out_count=%0d in_left=%0d", result_valid, out_count, in_left_sig);
                    end
                    read_one(ok, word);
                    exp = (sb.size() > 0) ? sb.pop_front() : '0;
                    vectors++;
                    if (!ok || word !== exp) begin miscompares++; $display("FAIL rand_%0d actual=%h expected=%h ok=%0d", j, word, exp, ok); end
                end
            end
        join
    endtask

    task automatic test_full();
        bit ok;
        logic [EW-1:0] word;
        logic [EW-1:0] exp;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            for (int k = 0; k < 500 && in_left_sig == '0; k++) cycle();
            write_one(i[0], W'(i + 3), W'(i + 1));
        end
        for (int k = 0; k < 2000 && !(out_count == CW'(DEPTH) && in_left_sig == '0); k++) cycle();
        repeat (20) cycle();
        vectors += 2;
        if (out_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL full_out_count actual=%0d expected=%0d", out_count, DEPTH); end
        if (in_left_sig !== '0) begin miscompares++; $display("FAIL full_in_left actual=%0d expected=0", in_left_sig); end
        write_one(1'b0, 8'd1, 8'd1);
        vectors++;
        if (in_overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_pulse actual=%0b expected=1", in_overflow); end
        cycle();
        vectors++;
        if (in_overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clear actual=%0b expected=0", in_overflow); end
        read_one(ok, word);
        exp = sb.pop_front();
        vectors += 2;
        if (!ok || word !== exp) begin miscompares++; $display("FAIL full_head actual=%h expected=%h ok=%0d", word, exp, ok); end
        if (out_count !== CW'(DEPTH - 1)) begin miscompares++; $display("FAIL after_read_count actual=%0d expected=%0d", out_count, DEPTH - 1); end
        cycle();
        vectors++;
        if (in_left_sig !== CW'(1)) begin miscompares++; $display("FAIL resume_pop actual=%0d expected=1", in_left_sig); end
        repeat (W) cycle();
        vectors++;
        if (out_count !== CW'(DEPTH - 1)) begin miscompares++; $display("FAIL resume_early actual=%0d expected=%0d", out_count, DEPTH - 1); end
        cycle();
        vectors++;
        if (out_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL resume_land actual=%0d expected=%0d", out_count, DEPTH); end
        for (int i = 0; i < 2 * DEPTH - 1; i++) begin
            read_one(ok, word);
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            vectors++;
            if (!ok || word !== exp) begin miscompares++; $display("FAIL drain_%0d actual=%h expected=%h ok=%0d", i, word, exp, ok); end
        end
    endtask

    task automatic test_reset_mid();
        write_one(1'b0, 8'd5, 8'd6);
        for (int k = 0; k < 100 && !result_valid; k++) cycle();
        for (int i = 0; i < 4; i++) begin
            write_one(1'b1, W'(50 + i), 8'd3);
        end
        vectors += 2;
        if (in_left_sig !== CW'(DEPTH - 3)) begin miscompares++; $display("FAIL pre_rst_in_left actual=%0d expected=%0d", in_left_sig, DEPTH - 3); end
        if (out_count !== CW'(1)) begin miscompares++; $display("FAIL pre_rst_out_count actual=%0d expected=1", out_count); end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_left_sig !== CW'(DEPTH)) begin miscompares++; $display("FAIL async_rst_in_left actual=%0d expected=%0d", in_left_sig, DEPTH); end
        cycle();
        rst = 1'b0;
        sb.delete();
        test_reset();
        repeat (40) cycle();
        vectors += 3;
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid actual=%0b expected=0", result_valid); end
        if (out_count !== '0) begin miscompares++; $display("FAIL post_rst_out_count actual=%0d expected=0", out_count); end
        if (in_left_sig !== CW'(DEPTH)) begin miscompares++; $display("FAIL post_rst_in_left actual=%0d expected=%0d", in_left_sig, DEPTH); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycle();
        test_reset();
        test_latency_mul();
        test_div();
        test_random();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
